// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared state encoding and request helpers for the burst memory controller
package mem_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_START,
      ST_RD_WAIT,
      ST_RD_DATA,
      ST_WR_START,
      ST_WR_WAIT,
      ST_WR_DATA
   } state_t;

   function automatic int bl_width(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

   // A zero-length request still moves one beat; oversize requests are clamped.
   function automatic int unsigned norm_len(input int unsigned len, input int unsigned max_burst);
      if (len == 0) return 1;
      if (len > max_burst) return max_burst;
      return len;
   endfunction

endpackage

// File: rtl/wait_counter.sv
// rtl/wait_counter.sv - loadable down-counter that stops at zero and flags a count of one
module wait_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             last
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (dec && count != '0)
         count <= count - CNT_W'(1);
   end

   assign last = (count == CNT_W'(1));

endmodule

// File: rtl/mem_ctrl_burst.sv
// rtl/mem_ctrl_burst.sv - burst memory controller with split read/write latency and a one-deep pending slot
module mem_ctrl_burst
   import mem_ctrl_pkg::*;
#(
   parameter int RD_WAIT   = 16,
   parameter int WR_WAIT   = 16,
   parameter int BEAT_WAIT = 2,
   parameter int MAX_BURST = 8,
   parameter int CNT_W     = 8,
   localparam int BL_W     = bl_width(MAX_BURST)
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            mstrobe,
   input  logic            mem_write,
   input  logic [BL_W-1:0] burst_len,
   output logic            pready,
   output logic            busy,
   output logic            drw,
   output logic            axi_start,
   output logic            beat_valid,
   output logic [BL_W-1:0] beat_idx,
   output logic            done,
   output logic            overflow
);

   state_t state, state_nxt;

   logic            cur_write, pend_valid, pend_write;
   logic [BL_W-1:0] cur_len, pend_len, beat, in_len;
   logic            is_idle, is_start, is_wait, is_data;
   logic            last_beat, wait_last, capture, cnt_load;
   logic [CNT_W-1:0] cnt_val;

   assign in_len    = BL_W'(norm_len(32'(burst_len), MAX_BURST));
   assign is_idle   = (state == ST_IDLE);
   assign is_start  = (state == ST_RD_START) || (state == ST_WR_START);
   assign is_wait   = (state == ST_RD_WAIT)  || (state == ST_WR_WAIT);
   assign is_data   = (state == ST_RD_DATA)  || (state == ST_WR_DATA);
   assign last_beat = (beat == cur_len - BL_W'(1));
   // In the final beat an incoming strobe is taken straight as the next request.
   assign capture   = mstrobe && !is_idle && !pend_valid && !(is_data && last_beat);

   assign cnt_load  = is_start || (is_data && !last_beat);
   assign cnt_val   = is_start ? CNT_W'((state == ST_WR_START) ? WR_WAIT : RD_WAIT)
                               : CNT_W'(BEAT_WAIT);

   wait_counter #(.CNT_W(CNT_W)) u_wait_counter (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (is_wait),
      .last     (wait_last)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:     if (mstrobe) state_nxt = mem_write ? ST_WR_START : ST_RD_START;
         ST_RD_START: state_nxt = ST_RD_WAIT;
         ST_WR_START: state_nxt = ST_WR_WAIT;
         ST_RD_WAIT:  if (wait_last) state_nxt = ST_RD_DATA;
         ST_WR_WAIT:  if (wait_last) state_nxt = ST_WR_DATA;
         ST_RD_DATA, ST_WR_DATA: begin
            if (!last_beat)
               state_nxt = (state == ST_WR_DATA) ? ST_WR_WAIT : ST_RD_WAIT;
            else if (pend_valid)
               state_nxt = pend_write ? ST_WR_START : ST_RD_START;
            else if (mstrobe)
               state_nxt = mem_write ? ST_WR_START : ST_RD_START;
            else
               state_nxt = ST_IDLE;
         end
         default:     state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur_write  <= 1'b0;
         cur_len    <= '0;
         pend_valid <= 1'b0;
         pend_write <= 1'b0;
         pend_len   <= '0;
         beat       <= '0;
      end else begin
         if (is_idle && mstrobe) begin
            cur_write <= mem_write;
            cur_len   <= in_len;
         end
         if (capture) begin
            pend_valid <= 1'b1;
            pend_write <= mem_write;
            pend_len   <= in_len;
         end
         if (is_data) begin
            if (!last_beat) begin
               beat <= beat + BL_W'(1);
            end else begin
               beat <= '0;
               if (pend_valid) begin
                  cur_write  <= pend_write;
                  cur_len    <= pend_len;
                  pend_valid <= 1'b0;
               end else if (mstrobe) begin
                  cur_write <= mem_write;
                  cur_len   <= in_len;
               end
            end
         end
      end
   end

   always_comb begin
      pready     = is_idle;
      busy       = !is_idle;
      drw        = !is_idle && cur_write;
      axi_start  = is_start;
      beat_valid = is_data;
      beat_idx   = beat;
      done       = is_data && last_beat;
      overflow   = mstrobe && !is_idle && pend_valid;
   end

endmodule

// File: tb/tb_mem_ctrl_burst.sv
// tb/tb_mem_ctrl_burst.sv - timeline-model checker plus directed cycle checks for mem_ctrl_burst
module tb_mem_ctrl_burst;

   localparam int RDW = 16;
   localparam int WRW = 16;
   localparam int BW  = 2;
   localparam int MB  = 8;
   localparam int BLW = 4;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic           mstrobe = 1'b0;
   logic           mem_write = 1'b0;
   logic [BLW-1:0] burst_len = '0;
   logic           pready, busy, drw, axi_start, beat_valid, done, overflow;
   logic [BLW-1:0] beat_idx;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   mem_ctrl_burst #(
      .RD_WAIT(RDW), .WR_WAIT(WRW), .BEAT_WAIT(BW), .MAX_BURST(MB), .CNT_W(8)
   ) dut (
      .clk(clk), .reset_n(reset_n), .mstrobe(mstrobe), .mem_write(mem_write),
      .burst_len(burst_len), .pready(pready), .busy(busy), .drw(drw),
      .axi_start(axi_start), .beat_valid(beat_valid), .beat_idx(beat_idx),
      .done(done), .overflow(overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Request timeline model: each request occupies [start, end] as a contiguous window.
   bit m_cur, m_pend, m_cur_wr, m_pend_wr, m_act, m_bv;
   int m_start, m_end, m_len, m_pend_len, m_off;

   function automatic int norm(input int l);
      if (l == 0) return 1;
      if (l > MB) return MB;
      return l;
   endfunction

   function automatic int end_of(input int s, input bit wr, input int len);
      return s + (wr ? WRW : RDW) + 1 + (len - 1) * (BW + 1);
   endfunction

   always @(negedge clk) begin
      if (!reset_n) begin
         m_cur  = 1'b0;
         m_pend = 1'b0;
         chk("rst_pready", pready, 1);
         chk("rst_busy", busy, 0);
         chk("rst_drw", drw, 0);
         chk("rst_axi_start", axi_start, 0);
         chk("rst_beat_valid", beat_valid, 0);
         chk("rst_beat_idx", beat_idx, 0);
         chk("rst_done", done, 0);
         chk("rst_overflow", overflow, 0);
      end else begin
         m_act = m_cur && cyc >= m_start && cyc <= m_end;
         m_off = cyc - m_start - 1 - (m_cur_wr ? WRW : RDW);
         m_bv  = m_act && m_off >= 0 && (m_off % (BW + 1)) == 0;
         chk("pready", pready, !m_act);
         chk("busy", busy, m_act);
         chk("drw", drw, m_act && m_cur_wr);
         chk("axi_start", axi_start, m_act && cyc == m_start);
         chk("beat_valid", beat_valid, m_bv);
         chk("done", done, m_act && cyc == m_end);
         chk("overflow", overflow, mstrobe && m_act && m_pend);
         if (m_bv)
            chk("beat_idx", beat_idx, m_off / (BW + 1));
         else if (!m_act)
            chk("idle_beat_idx", beat_idx, 0);
         if (mstrobe) begin
            if (!m_act) begin
               m_cur    = 1'b1;
               m_cur_wr = mem_write;
               m_len    = norm(int'(burst_len));
               m_start  = cyc + 1;
               m_end    = end_of(m_start, m_cur_wr, m_len);
            end else if (!m_pend) begin
               m_pend     = 1'b1;
               m_pend_wr  = mem_write;
               m_pend_len = norm(int'(burst_len));
            end
         end
         if (m_act && cyc == m_end) begin
            if (m_pend) begin
               m_cur_wr = m_pend_wr;
               m_len    = m_pend_len;
               m_start  = cyc + 1;
               m_end    = end_of(m_start, m_cur_wr, m_len);
               m_pend   = 1'b0;
            end else begin
               m_cur = 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go(input bit wr, input int len);
      mem_write = wr;
      burst_len = len[BLW-1:0];
      mstrobe   = 1'b1;
   endtask

   task automatic strobe(input bit wr, input int len, output int t);
      t = cyc;
      go(wr, len);
      tick();
      mstrobe = 1'b0;
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) tick();
      if (cyc != t) chk("wait_to", cyc, t);
      #1;
   endtask

   int t0, t1;

   initial begin
      repeat (3) tick();
      reset_n = 1'b1;
      tick();

      // single read beat
      strobe(0, 1, t0);
      wait_to(t0 + 1);
      chk("t1_axi_start", axi_start, 1);
      chk("t1_drw", drw, 0);
      wait_to(t0 + 18);
      chk("t1_done", done, 1);
      chk("t1_beat_valid", beat_valid, 1);
      wait_to(t0 + 19);
      chk("t1_pready", pready, 1);

      // four-beat write
      strobe(1, 4, t0);
      for (int k = 0; k < 4; k++) begin
         wait_to(t0 + 18 + 3 * k);
         chk("t2_beat_valid", beat_valid, 1);
         chk("t2_beat_idx", beat_idx, k);
         chk("t2_done", done, (k == 3));
         chk("t2_drw", drw, 1);
      end
      wait_to(t0 + 28);
      chk("t2_pready", pready, 1);

      // queued write behind a read
      strobe(0, 1, t0);
      wait_to(t0 + 5);
      strobe(1, 2, t1);
      wait_to(t0 + 18);
      chk("t3_rd_done", done, 1);
      wait_to(t0 + 19);
      chk("t3_wr_start", axi_start, 1);
      chk("t3_no_idle", pready, 0);
      chk("t3_drw", drw, 1);
      wait_to(t0 + 36);
      chk("t3_beat0", beat_valid, 1);
      chk("t3_beat0_idx", beat_idx, 0);
      wait_to(t0 + 39);
      chk("t3_beat1_done", done, 1);
      chk("t3_beat1_idx", beat_idx, 1);
      wait_to(t0 + 40);
      chk("t3_pready", pready, 1);

      // third strobe with slot full is dropped
      strobe(0, 1, t0);
      wait_to(t0 + 3);
      strobe(1, 1, t1);
      wait_to(t0 + 5);
      go(1, 3);
      #1;
      chk("t4_overflow", overflow, 1);
      tick();
      mstrobe = 1'b0;
      #1;
      chk("t4_overflow_pulse", overflow, 0);
      wait_to(t0 + 36);
      chk("t4_wr_done", done, 1);
      wait_to(t0 + 37);
      chk("t4_dropped_not_run", pready, 1);

      // length clamps
      strobe(0, 0, t0);
      wait_to(t0 + 18);
      chk("t5_len0_done", done, 1);
      wait_to(t0 + 19);
      chk("t5_len0_pready", pready, 1);
      strobe(0, 9, t0);
      wait_to(t0 + 39);
      chk("t5_len9_done", done, 1);
      chk("t5_len9_idx", beat_idx, 7);
      wait_to(t0 + 40);
      chk("t5_len9_pready", pready, 1);

      // reset mid-wait with a pending request
      strobe(0, 1, t0);
      wait_to(t0 + 3);
      strobe(1, 2, t1);
      wait_to(t0 + 10);
      reset_n = 1'b0;
      #1;
      chk("t6_rst_pready", pready, 1);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_done", done, 0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      strobe(1, 1, t0);
      wait_to(t0 + 18);
      chk("t6_after_done", done, 1);
      wait_to(t0 + 19);
      chk("t6_after_pready", pready, 1);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog at cycle %0d: got timeout expected completion", cyc);
      $fatal(1);
   end

endmodule

// File: doc/mem_ctrl_burst.md
Name: mem_ctrl_burst

Overview:
- Parametrised successor to the single-access wait-state memory controller; sits between the processor strobe interface and the SDRAM/AXI side.
- Separate read and write latencies.
- Multi-beat bursts with a programmable inter-beat wait.
- A one-deep pending-request slot, so a strobe that arrives while the controller is busy is queued, not lost.

Parameters:
- RD_WAIT, 16, wait cycles from read start to first beat (1..2^CNT_W-1).
- WR_WAIT, 16, wait cycles from write start to first beat (1..2^CNT_W-1).
- BEAT_WAIT, 2, wait cycles between consecutive beats of a burst (1..2^CNT_W-1).
- MAX_BURST, 8, maximum beats per request (>=1).
- CNT_W, 8, wait-counter width.

Ports:
- clk  in  1  clock, all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mstrobe  in  1  request strobe, sampled every rising edge.
- mem_write  in  1  1=write, 0=read; qualified by mstrobe.
- burst_len  in  BL_W=$clog2(MAX_BURST+1)  beats requested; qualified by mstrobe.
- pready  out  1  controller idle and ready.
- busy  out  1  access in progress.
- drw  out  1  direction to SDRAM (1=write), valid while busy.
- axi_start  out  1  one-cycle pulse in each START state.
- beat_valid  out  1  high in each DATA state.
- beat_idx  out  BL_W  index of the current beat (0-based).
- done  out  1  one-cycle pulse in the final DATA state of a request.
- overflow  out  1  one-cycle pulse when a strobe is dropped.

Behaviour:
- States: IDLE, RD_START, RD_WAIT, RD_DATA, WR_START, WR_WAIT, WR_DATA. All outputs decode combinationally from state plus registers.
- Reset (async, reset_n=0):
  - state=IDLE, pending slot empty, counters and beat registers 0.
  - Outputs: pready=1; busy, drw, axi_start, beat_valid, beat_idx, done, overflow all 0.
  - Reset asserted mid-access aborts it immediately, with no done pulse.
- Length normalisation: effective length = 1 if burst_len==0, MAX_BURST if burst_len>MAX_BURST, else burst_len.
- IDLE:
  - mstrobe=1 latches mem_write and effective length.
  - Next state is WR_START if mem_write=1, else RD_START; otherwise stay.
  - pready=1 only in IDLE.
- START (1 cycle):
  - Load wait counter with RD_WAIT or WR_WAIT; beat_idx=0; axi_start=1.
  - Next state is the matching WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When the counter value equals 1, next state is DATA, so WAIT lasts exactly the loaded count.
- DATA (1 cycle):
  - beat_valid=1.
  - If beat_idx < length-1: beat_idx increments, counter loads BEAT_WAIT, and the state returns to WAIT.
  - Otherwise done=1 and the request completes.
- Completion:
  - If the pending slot is valid, go directly to RD_START or WR_START of the pending request (no IDLE cycle) and clear the slot.
  - Otherwise go to IDLE.
- Latency, single beat: strobe sampled at edge 0 → START cycle 1 → WAIT cycles 2..W+1 → DATA/done cycle W+2 → IDLE cycle W+3.
- Pending slot:
  - A strobe in any non-IDLE state with the slot empty is captured (direction plus normalised length).
  - A strobe with the slot full is dropped and overflow pulses.
  - A strobe in the final DATA cycle with the slot empty is captured and served next.
- drw holds the current request's direction in all non-IDLE states. busy = !pready.
- Counter is CNT_W bits and never wraps: it is only decremented while its value is >=1 in WAIT.

Decomposition:
- Package mem_ctrl_pkg:
  - state enum/encodings for the seven states;
  - BL_W computation function;
  - length-normalisation function.
- Sub-module wait_counter: CNT_W-bit loadable down-counter.
  - Inputs: clk, reset_n, load, load_val, dec.
  - Output: last (count==1).

Test Plan:
- Read, RD_WAIT=16, burst_len=1, mstrobe at cycle 0:
  - axi_start in cycle 1;
  - beat_valid/done in cycle 18;
  - pready=1 again in cycle 19;
  - drw=0 throughout.
- Write, WR_WAIT=16, BEAT_WAIT=2, burst_len=4:
  - beat_valid in cycles 18, 21, 24, 27 with beat_idx 0..3;
  - done only in cycle 27;
  - drw=1.
- Queued request: read of length 1 started, second strobe (write, length 2) at cycle 5:
  - read done in cycle 18;
  - WR_START in cycle 19 with no IDLE cycle;
  - beats in cycles 36 and 39.
- Overflow: third strobe while the pending slot is full:
  - overflow=1 for one cycle;
  - the dropped request is never executed.
- Length clamp, MAX_BURST=8:
  - burst_len=0 → 1 beat;
  - burst_len=9 → 8 beats, beat_idx ends at 7.
- reset_n low at cycle 10 mid-WAIT:
  - immediately IDLE, pready=1;
  - pending slot cleared, no done;
  - a new strobe after release proceeds with normal latency.
